// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter.
// Requester indices double as bit positions in the pending vector.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPENING,
    OPEN,
    CLOSING
  } gate_state_t;

  localparam logic [1:0] REQ_HEXIT  = 2'd0;
  localparam logic [1:0] REQ_NEXIT  = 2'd1;
  localparam logic [1:0] REQ_HENTRY = 2'd2;
  localparam logic [1:0] REQ_NENTRY = 2'd3;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable saturating down-counter; done marks the last cycle of a phase.
// A phase loaded with N therefore lasts exactly N cycles.
module gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Barrier gate arbiter for normal/handicapped entry and exit requesters.
// Define PASS_SENSOR_EN to wait on car_pass (with timeout) instead of a fixed hold.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int MOVE_CYCLES    = 4,
  parameter int OPEN_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_entry,
  input  logic       n_exit,
  input  logic       h_entry,
  input  logic       h_exit,
  input  logic       N_full,
  input  logic       H_full,
  input  logic       N_empty,
  input  logic       H_empty,
`ifdef PASS_SENSOR_EN
  input  logic       car_pass,
`endif
  output logic       gate_up,
  output logic       gate_down,
  output logic       gate_open,
  output logic       n_inc,
  output logic       n_dec,
  output logic       h_inc,
  output logic       h_dec,
  output logic       denied,
  output logic [3:0] pending,
  output logic       busy
);

  localparam int TMAX = max3(MOVE_CYCLES, OPEN_CYCLES, TIMEOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_MOVE = TW'(MOVE_CYCLES);
`ifdef PASS_SENSOR_EN
  localparam logic [TW-1:0] T_OPEN = TW'(TIMEOUT_CYCLES);
`else
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES);
`endif

  gate_state_t state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  upd_q, upd_d;
  logic [1:0]  win_q, win_d;
  logic        den_q, den_d;
  logic [1:0]  sel;
  logic        t_load;
  logic [TW-1:0] t_val;
  logic        t_done;
  logic [3:0]  req;
  logic [3:0]  ok;

  assign req = {n_entry, h_entry, n_exit, h_exit};
  assign ok  = {~N_full, ~H_full, ~N_empty, ~H_empty};

  gate_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (t_load),
    .val_i  (t_val),
    .done_o (t_done)
  );

  // Exits win: they free space for the entries behind them.
  always_comb begin
    sel = REQ_NENTRY;
    priority case (1'b1)
      pend_q[REQ_HEXIT]:  sel = REQ_HEXIT;
      pend_q[REQ_NEXIT]:  sel = REQ_NEXIT;
      pend_q[REQ_HENTRY]: sel = REQ_HENTRY;
      default:            sel = REQ_NENTRY;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    win_d   = win_q;
    upd_d   = '0;
    den_d   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          pend_d[sel] = 1'b0;
          if (ok[sel]) begin
            state_d = OPENING;
            win_d   = sel;
            t_load  = 1'b1;
            t_val   = T_MOVE;
          end else begin
            den_d = 1'b1;
          end
        end
      end
      OPENING: begin
        if (t_done) begin
          state_d = OPEN;
          t_load  = 1'b1;
          t_val   = T_OPEN;
        end
      end
      OPEN: begin
`ifdef PASS_SENSOR_EN
        if (car_pass) begin
          state_d      = CLOSING;
          t_load       = 1'b1;
          t_val        = T_MOVE;
          upd_d[win_q] = 1'b1;
        end else if (t_done) begin
          state_d = CLOSING;
          t_load  = 1'b1;
          t_val   = T_MOVE;
          den_d   = 1'b1;
        end
`else
        if (t_done) begin
          state_d      = CLOSING;
          t_load       = 1'b1;
          t_val        = T_MOVE;
          upd_d[win_q] = 1'b1;
        end
`endif
      end
      CLOSING: begin
        if (t_done) begin
          state_d = IDLE;
          t_load  = 1'b1;
        end
      end
    endcase
    // New pulses win over the grant clear, so a returning requester re-latches.
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (ok[i])
          pend_d[i] = 1'b1;
        else
          den_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      win_q   <= '0;
      upd_q   <= '0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      win_q   <= win_d;
      upd_q   <= upd_d;
      den_q   <= den_d;
    end
  end

  assign gate_up   = (state_q == OPENING);
  assign gate_open = (state_q == OPEN);
  assign gate_down = (state_q == CLOSING);
  assign busy      = (state_q != IDLE);
  assign pending   = pend_q;
  assign denied    = den_q;
  assign h_dec     = upd_q[REQ_HEXIT];
  assign n_dec     = upd_q[REQ_NEXIT];
  assign h_inc     = upd_q[REQ_HENTRY];
  assign n_inc     = upd_q[REQ_NENTRY];

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: vector table plus service sequences.
// Sensor sequences run only when PASS_SENSOR_EN is defined.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] flg;
`ifdef PASS_SENSOR_EN
  logic       car_pass;
`endif
  logic       gate_up, gate_down, gate_open;
  logic       n_inc, n_dec, h_inc, h_dec;
  logic       denied, busy;
  logic [3:0] pending;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .MOVE_CYCLES    (4),
    .OPEN_CYCLES    (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .n_entry   (req[3]),
    .h_entry   (req[2]),
    .n_exit    (req[1]),
    .h_exit    (req[0]),
    .N_full    (flg[3]),
    .H_full    (flg[2]),
    .N_empty   (flg[1]),
    .H_empty   (flg[0]),
`ifdef PASS_SENSOR_EN
    .car_pass  (car_pass),
`endif
    .gate_up   (gate_up),
    .gate_down (gate_down),
    .gate_open (gate_open),
    .n_inc     (n_inc),
    .n_dec     (n_dec),
    .h_inc     (h_inc),
    .h_dec     (h_dec),
    .denied    (denied),
    .pending   (pending),
    .busy      (busy)
  );

  // req = {n_entry,h_entry,n_exit,h_exit}; flg = {N_full,H_full,N_empty,H_empty}
  // g = {up,down,open}; u = {n_inc,h_inc,n_dec,h_dec}
  typedef struct {
    string      nm;
    logic [3:0] req;
    logic [3:0] flg;
    logic [2:0] g;
    logic [3:0] u;
    logic       d;
    logic [3:0] p;
    logic       b;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [2:0] g,
                     input logic [3:0] u, input logic d,
                     input logic [3:0] p, input logic b);
    logic [12:0] e, a;
    e = {g, u, d, p, b};
    a = {gate_up, gate_down, gate_open, n_inc, h_inc, n_dec, h_dec,
         denied, pending, busy};
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (up,dn,op,ni,hi,nd,hd,den,pend[4],busy)",
               nm, a, e);
    end
  endtask

  // One service from the grant edge. d=1 means a sensor timeout close;
  // otherwise the sensor build reports passage on the last open cycle.
  task automatic svc(input string nm, input logic [3:0] u, input logic d,
                     input int ol, input int ncyc, input logic [3:0] p0,
                     input int inj, input logic [3:0] ireq,
                     input logic [3:0] p1);
    int tot;
    logic [2:0] g;
    tot = 8 + ol;
    if (ncyc < tot) tot = ncyc;
    for (int c = 0; c < tot; c++) begin
      req = ((inj >= 0) && (c == inj || c == inj + 4)) ? ireq : 4'b0000;
`ifdef PASS_SENSOR_EN
      car_pass = !d && (c == 4 + ol);
`endif
      step();
      g = (c < 4) ? 3'b100 : (c < 4 + ol) ? 3'b001 : 3'b010;
      chk(nm, g, (c == 4 + ol) ? u : 4'b0000, (c == 4 + ol) ? d : 1'b0,
          (inj >= 0 && c >= inj) ? p1 : p0, 1'b1);
    end
    req = 4'b0000;
`ifdef PASS_SENSOR_EN
    car_pass = 1'b0;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"n_entry_full",   4'b1000, 4'b1000, 3'b000, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[1] = '{"full_quiet",     4'b0000, 4'b1000, 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[2] = '{"h_exit_empty",   4'b0001, 4'b0001, 3'b000, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[3] = '{"empty_quiet",    4'b0000, 4'b0001, 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[4] = '{"h_entry_full",   4'b0100, 4'b0100, 3'b000, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[5] = '{"n_exit_empty",   4'b0010, 4'b0010, 3'b000, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[6] = '{"quiet",          4'b0000, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[7] = '{"mixed_latch",    4'b1001, 4'b1000, 3'b000, 4'b0000, 1'b1, 4'b0001, 1'b0};

    reset = 1'b0;
    req   = 4'b0000;
    flg   = 4'b0000;
`ifdef PASS_SENSOR_EN
    car_pass = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("in_reset", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    reset = 1'b1;
    step();
    chk("after_reset", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      flg = tbl[i].flg;
      step();
      chk(tbl[i].nm, tbl[i].g, tbl[i].u, tbl[i].d, tbl[i].p, tbl[i].b);
    end
    flg = 4'b0000;
    svc("h_exit_svc", 4'b0001, 1'b0, 16, 24, 4'b0000, -1, 4'b0000, 4'b0000);
    step();
    chk("h_exit_done", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    req = 4'b1000;
    step();
    chk("n_entry_pend", 3'b000, 4'b0000, 1'b0, 4'b1000, 1'b0);
    svc("n_entry_svc", 4'b1000, 1'b0, 16, 24, 4'b0000, -1, 4'b0000, 4'b0000);
    step();
    chk("n_entry_done", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    req = 4'b0110;
    step();
    chk("pair_pend", 3'b000, 4'b0000, 1'b0, 4'b0110, 1'b0);
    svc("n_exit_first", 4'b0010, 1'b0, 16, 24, 4'b0100, -1, 4'b0000, 4'b0000);
    step();
    chk("idle_gap", 3'b000, 4'b0000, 1'b0, 4'b0100, 1'b0);
    svc("h_entry_second", 4'b0100, 1'b0, 16, 24, 4'b0000, -1, 4'b0000, 4'b0000);
    step();
    chk("pair_done", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    req = 4'b0001;
    step();
    chk("h_exit_pend", 3'b000, 4'b0000, 1'b0, 4'b0001, 1'b0);
    svc("h_exit_inject", 4'b0001, 1'b0, 16, 24, 4'b0000, 5, 4'b1000, 4'b1000);
    flg = 4'b1000;
    step();
    chk("refuse_wait", 3'b000, 4'b0000, 1'b0, 4'b1000, 1'b0);
    step();
    chk("grant_refused", 3'b000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    step();
    chk("refused_quiet", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    flg = 4'b0000;

    req = 4'b0100;
    step();
    chk("cut_pend", 3'b000, 4'b0000, 1'b0, 4'b0100, 1'b0);
    svc("h_entry_cut", 4'b0100, 1'b0, 16, 10, 4'b0000, 6, 4'b1000, 4'b1000);
    reset = 1'b0;
    #1;
    chk("reset_async", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("reset_hold", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    reset = 1'b1;
    step();
    chk("reset_release", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    req = 4'b0010;
    step();
    chk("restart_pend", 3'b000, 4'b0000, 1'b0, 4'b0010, 1'b0);
    svc("restart_svc", 4'b0010, 1'b0, 16, 24, 4'b0000, -1, 4'b0000, 4'b0000);
    step();
    chk("restart_done", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);

`ifdef PASS_SENSOR_EN
    req = 4'b0100;
    step();
    chk("timeout_pend", 3'b000, 4'b0000, 1'b0, 4'b0100, 1'b0);
    svc("h_entry_timeout", 4'b0000, 1'b1, 64, 72, 4'b0000, -1, 4'b0000, 4'b0000);
    step();
    chk("timeout_done", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    req = 4'b0100;
    step();
    chk("pass_pend", 3'b000, 4'b0000, 1'b0, 4'b0100, 1'b0);
    svc("h_entry_pass5", 4'b0100, 1'b0, 5, 13, 4'b0000, -1, 4'b0000, 4'b0000);
    step();
    chk("pass_done", 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Controller that shares one physical barrier gate among the four parking requesters: normal entry, normal exit, handicapped entry and handicapped exit. It latches request pulses, arbitrates them, and sequences the gate motor through open, hold and close phases. After each completed passage it emits exactly one single-cycle update pulse to the normal or handicapped occupancy counter. It sits between the push-button/sensor front end and the two parking counters, using their full/empty flags to refuse impossible moves.

## Interface
- MOVE_CYCLES, 4: cycles the motor drives up or down (≥1)
- OPEN_CYCLES, 16: hold time with the gate open (≥1)
- TIMEOUT_CYCLES, 64: maximum open wait for a car (sensor build only, ≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- n_entry, n_exit, h_entry, h_exit  in  1 each  single-cycle request pulses, already synchronized
- N_full, H_full  in  1 each  lot full flags from the counters
- N_empty, H_empty  in  1 each  lot empty flags from the counters
- car_pass  in  1  passage sensor pulse (present only with PASS_SENSOR_EN)
- gate_up, gate_down  out  1 each  motor drive, never both 1
- gate_open  out  1  gate is fully open
- n_inc, n_dec, h_inc, h_dec  out  1 each  single-cycle counter update pulses
- denied  out  1  single-cycle pulse when a request is refused or a service aborts
- pending  out  4  latched requests {n_entry, h_entry, n_exit, h_exit}, MSB to LSB
- busy  out  1  FSM not in IDLE

## Operation
- Request latching: a pulse sets its pending bit. A pulse on an already-set bit is absorbed, not queued.
- Refusal at arrival: an entry pulse while its lot is full, or an exit pulse while its lot is empty, does not latch and gives denied=1 on the next cycle.
- Arbitration (IDLE only): fixed priority h_exit > n_exit > h_entry > n_entry. Exits go first because they free space.
- Refusal at grant: a selected entry whose lot is now full, or a selected exit whose lot is now empty, has its bit cleared and produces denied. The FSM stays in IDLE and re-arbitrates next cycle.
- On grant, the winner's pending bit clears. The winner index is registered and held until IDLE.
- A new pulse from the requester being served re-sets its pending bit; it is treated as a new car.
- FSM states:
  - IDLE → OPENING on a valid grant.
  - OPENING: gate_up=1 for MOVE_CYCLES, then → OPEN.
  - OPEN: gate_open=1. When the pass condition is met → CLOSING.
  - CLOSING: gate_down=1 for MOVE_CYCLES, then → IDLE.
- Pass condition and update pulse:
  - On the OPEN → CLOSING transition, exactly one pulse fires for the granted requester.
  - Mapping: h_exit → h_dec, n_exit → n_dec, h_entry → h_inc, n_entry → n_inc.
- Timer: one shared down-counter, width $clog2(max(MOVE_CYCLES, OPEN_CYCLES, TIMEOUT_CYCLES)+1). It is loaded on each state entry and never wraps.
- Simultaneous pulses on several requesters in one cycle all latch.

## Timing
- Reset values: all outputs 0, pending=0, state IDLE, timer 0.
- Reset asserted mid-operation: immediate return to IDLE. No update pulse is emitted and pending requests are lost.
- Pulse to pending bit visible: 1 cycle.
- Pending visible to gate_up=1: 1 cycle (grant registered).
- Total service without sensor: exactly 2·MOVE_CYCLES + OPEN_CYCLES cycles of busy=1.
- Update pulse: asserted in the first CLOSING cycle, coincident with the first gate_down=1.
- denied and all update pulses are exactly one cycle wide.

## Configuration
- PASS_SENSOR_EN defined:
  - car_pass port exists and OPEN waits for car_pass, loaded with TIMEOUT_CYCLES.
  - car_pass=1 → CLOSING with the update pulse.
  - Timeout expiry → CLOSING with denied=1 and no update pulse.
  - OPEN_CYCLES is unused.
- PASS_SENSOR_EN undefined:
  - No car_pass port; OPEN lasts exactly OPEN_CYCLES.
  - Passage is assumed, so the update pulse always fires.

## Structure
- Shared package parking_pkg:
  - gate_state_t enum {IDLE, OPENING, OPEN, CLOSING}.
  - Requester index constants REQ_HEXIT=0, REQ_NEXIT=1, REQ_HENTRY=2, REQ_NENTRY=3.
- One sub-module gate_timer: loadable down-counter with a done flag, parameterized width.

## Test plan
- After reset deassert: all outputs 0. An n_entry pulse gives pending=4'b1000 one cycle later, then gate_up for 4 cycles, gate_open for 16, gate_down for 4. n_inc fires once in the first gate_down cycle.
- h_entry and n_exit pulsed together (N_full=0, H_full=0): n_exit is served first (n_dec), then h_entry (h_inc). busy stays high across both services apart from a 1-cycle IDLE gap.
- n_entry with N_full=1: denied one cycle later, pending stays 0, gate never moves. h_exit with H_empty=1: same result.
- n_entry pending while another requester is served, then N_full rises: when n_entry is selected, denied pulses, the bit clears, and the gate stays closed.
- reset driven low during OPEN: all outputs 0 at once, pending=0, no update pulse. After release, the FSM starts in IDLE.
- PASS_SENSOR_EN, TIMEOUT_CYCLES=64, no car_pass: after 64 OPEN cycles, gate_down starts with denied=1 and no h_inc. Repeat with car_pass at OPEN cycle 5: h_inc fires and CLOSING starts the next cycle.
